// File: rtl/cp0_timer_pkg.sv
// Shared CP0 register addresses and reset values used by every cp0_* register block.
package cp0_timer_pkg;

  localparam logic [5:0]  cp0addr_Count     = 6'd9;
  localparam logic [5:0]  cp0addr_Compare   = 6'd11;

  localparam logic [31:0] CP0_COUNT_RESET   = 32'h0000_0000;
  localparam logic [31:0] CP0_COMPARE_RESET = 32'h0000_0000;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances every other cycle and equal pulses
// once in the cycle after Count takes a value matching Compare.
module cp0_timer
  import cp0_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mtc0_we,
  input  logic [5:0]  cp0_addr,
  input  logic [31:0] mtc0_data,
  output logic [31:0] cp0_Count_data,
  output logic [31:0] cp0_Compare_data,
  output logic        equal
);

  logic        r_tick;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_equal;

  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_count_upd;
  logic [31:0] w_count_next;
  logic [31:0] w_compare_next;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    w_wr_count     = 1'b0;
    w_wr_compare   = 1'b0;
    w_count_upd    = 1'b0;
    w_count_next   = r_count;
    w_compare_next = r_compare;
    if (mtc0_we) begin
      w_wr_count   = (cp0_addr == cp0addr_Count);
      w_wr_compare = (cp0_addr == cp0addr_Compare);
    end
    // A write wins over the half-rate increment and is loaded unmodified.
    if (w_wr_count) begin
      w_count_next = mtc0_data;
      w_count_upd  = 1'b1;
    end else if (r_tick) begin
      w_count_next = r_count + 32'd1;
      w_count_upd  = 1'b1;
    end
    if (w_wr_compare) begin
      w_compare_next = mtc0_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick <= 1'b0;
    end else if (w_wr_count) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= ~r_tick;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= CP0_COUNT_RESET;
    end else begin
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_compare <= CP0_COMPARE_RESET;
    end else begin
      r_compare <= w_compare_next;
    end
  end

  // Only a Count update can raise a match; a Compare write in the same cycle masks it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_equal <= 1'b0;
    end else begin
      r_equal <= w_count_upd && !w_wr_compare && (w_count_next == w_compare_next);
    end
  end

  assign cp0_Count_data   = r_count;
  assign cp0_Compare_data = r_compare;
  assign equal            = r_equal;

endmodule

// File: tb/tb_cp0_timer.sv
// Scoreboard bench for cp0_timer: a cycle-level reference model queues expected
// register/equal values and a negedge monitor compares them against the DUT.
module tb_cp0_timer;
  import cp0_timer_pkg::*;

  logic        clk;
  logic        rst;
  logic        mtc0_we;
  logic [5:0]  cp0_addr;
  logic [31:0] mtc0_data;
  logic [31:0] cp0_Count_data;
  logic [31:0] cp0_Compare_data;
  logic        equal;

  cp0_timer dut (
    .clk              (clk),
    .rst              (rst),
    .mtc0_we          (mtc0_we),
    .cp0_addr         (cp0_addr),
    .mtc0_data        (mtc0_data),
    .cp0_Count_data   (cp0_Count_data),
    .cp0_Compare_data (cp0_Compare_data),
    .equal            (equal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] count;
    logic [31:0] compare;
    logic        eq;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Model: Count = last loaded value + (cycles since that load)/2.
  logic [31:0] m_base;
  int unsigned m_n;
  logic [31:0] m_cmp;
  logic        m_eq;

  function automatic logic [31:0] m_count();
    return m_base + 32'(m_n / 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input logic r, input logic we, input logic [5:0] a, input logic [31:0] d);
    logic wc, wp;
    rst = r; mtc0_we = we; cp0_addr = a; mtc0_data = d;
    @(posedge clk);
    wc = we && (a == cp0addr_Count);
    wp = we && (a == cp0addr_Compare);
    if (r) begin
      m_base = 32'h0; m_n = 0; m_cmp = 32'h0; m_eq = 1'b0;
    end else begin
      if (wp) m_cmp = d;
      if (wc) begin
        m_base = d; m_n = 0;
        m_eq = (d == m_cmp) && !wp;
      end else begin
        m_n++;
        m_eq = (m_n % 2 == 0) && (m_count() == m_cmp) && !wp;
      end
    end
    q_exp.push_back('{count: m_count(), compare: m_cmp, eq: m_eq});
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'd0, 32'h0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, a, d);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      check("count",   cp0_Count_data,   e.count);
      check("compare", cp0_Compare_data, e.compare);
      check("equal",   {31'h0, equal},   {31'h0, e.eq});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0]  a;
    logic [31:0] d;
    m_base = 0; m_n = 0; m_cmp = 0; m_eq = 0;
    rst = 1'b1; mtc0_we = 1'b0; cp0_addr = 6'd0; mtc0_data = 32'h0;

    // Reset overrides a concurrent Count write.
    step(1'b1, 1'b1, cp0addr_Count, 32'h7);
    step(1'b1, 1'b0, 6'd0, 32'h0);
    // Free run, no spurious match at 0/0.
    idle(8);

    // Compare ahead of Count: single pulse at 0x10.
    step(1'b1, 1'b0, 6'd0, 32'h0);
    wr(cp0addr_Compare, 32'h10);
    idle(40);

    // Compare written to the current Count value: no pulse.
    idle(3);
    wr(cp0addr_Compare, m_count());
    idle(4);

    // Write-to-match.
    wr(cp0addr_Compare, 32'h55);
    wr(cp0addr_Count, 32'h55);
    idle(4);

    // Wrap through zero.
    wr(cp0addr_Compare, 32'h0);
    wr(cp0addr_Count, 32'hFFFF_FFFE);
    idle(6);

    // Collision: increment to 0x20 in the same cycle Compare is written 0x20.
    wr(cp0addr_Count, 32'h1F);
    idle(1);
    wr(cp0addr_Compare, 32'h20);
    idle(4);
    wr(cp0addr_Count, 32'h20);
    idle(3);

    // Ignored address.
    wr(6'd12, 32'h1234);
    idle(2);

    // Reset in the cycle a match occurs, with a Count write pending.
    wr(cp0addr_Compare, 32'h30);
    wr(cp0addr_Count, 32'h2F);
    idle(1);
    step(1'b1, 1'b1, cp0addr_Count, 32'h7);
    idle(3);

    // Randomised traffic biased toward near-match values.
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    a = cp0addr_Count;
        2, 3:    a = cp0addr_Compare;
        4:       a = 6'($urandom);
        default: a = 6'd0;
      endcase
      d = ($urandom_range(0, 3) == 0) ? $urandom : m_count() + 32'($urandom_range(0, 6));
      step($urandom_range(0, 99) == 0, a != 6'd0, a, d);
    end

    @(negedge clk);
    #1;
    check("drain", 32'(q_exp.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cp0_timer.md
CP0_TIMER -- requirements
Module: cp0_timer

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port mtc0_we, input, 1 bit: CP0 register write strobe from the mtc0 path.
REQ-004 SHALL have port cp0_addr, input, 6 bits: CP0 register address of the write.
REQ-005 SHALL have port mtc0_data, input, 32 bits: write data.
REQ-006 SHALL have port cp0_Count_data, output, 32 bits: Count register (read by the mfc0 mux).
REQ-007 SHALL have port cp0_Compare_data, output, 32 bits: Compare register (read by the mfc0 mux).
REQ-008 SHALL have port equal, output, 1 bit: timer match pulse, consumed by cp0_Cause to set TI.
REQ-009 SHALL take Count/Compare addresses as the constants cp0addr_Count and cp0addr_Compare; no parameters.

Function
REQ-010 SHALL keep an internal 1-bit tick toggle that inverts every cycle; Count increments by 1 only in cycles where tick is 1, i.e. at half the clock rate.
REQ-011 SHALL wrap Count from 0xFFFFFFFF to 0x00000000 with no flag or stall.
REQ-012 SHALL, on mtc0_we with cp0_addr==cp0addr_Count, load Count with mtc0_data at the next edge and clear tick to 0.
REQ-013 SHALL give a Count write priority over a same-cycle increment: the written value is loaded unmodified.
REQ-014 SHALL, on mtc0_we with cp0_addr==cp0addr_Compare, load Compare with mtc0_data at the next edge.
REQ-015 SHALL ignore mtc0_we for any other address: Count keeps counting and Compare holds.
REQ-016 SHALL drive equal as a registered single-cycle pulse: it is 1 in the cycle after Count takes a new value, by increment or by write, that equals the Compare value in effect after that same edge.
REQ-017 SHALL NOT assert equal when only Compare changes, including when Compare is written to the current Count value.
REQ-018 SHALL suppress equal for a match created in a cycle in which Compare is also written; the newly written Compare is used for later matches.
REQ-019 SHALL hold equal high for exactly one cycle per match, even though Count stays at the matching value for two cycles.
REQ-020 SHALL have zero-cycle read latency: cp0_Count_data and cp0_Compare_data are the register outputs directly.

Reset
REQ-021 SHALL, when rst=1 at a clock edge, set Count=0x00000000, Compare=0x00000000, tick=0 and equal=0, overriding any same-cycle mtc0_we.
REQ-022 SHALL NOT assert equal because Count and Compare are both 0 after reset; a match requires a Count update after reset.
REQ-023 SHALL, if reset is asserted while an equal pulse is pending, drop the pulse (equal=0 in the cycle after reset).

Structure
REQ-024 SHALL take cp0addr_Count, cp0addr_Compare and the Count/Compare reset values from the shared defines header used by all cp0_* registers; no local copies.
REQ-025 SHALL be a single flat module with no sub-module; match detection and the counter live in one always block per register.
REQ-026 SHALL be instantiated beside cp0_Cause, sharing its mtc0_we/cp0_addr/mtc0_data, with equal wired to cp0_Cause's equal input.

Verification
REQ-027 Free run: release rst, no writes -> Count reads 0,0,1,1,2,2,... on successive cycles; equal stays 0.
REQ-028 Match: write Compare=0x10, let Count run from 0 -> equal=1 for exactly the one cycle after Count becomes 0x10, then 0.
REQ-029 Write-to-match: Compare=0x55, then write Count=0x55 -> equal pulses once, and Count holds 0x55 for two cycles (tick cleared).
REQ-030 Wrap: write Count=0xFFFFFFFE, Compare=0x00000000 -> Count goes 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; equal pulses after the 0x00000000 load.
REQ-031 Collision: same cycle Count increments to 0x20 while Compare is written 0x20 -> no equal; write Count=0x20 later -> equal pulses.
REQ-032 Reset mid-run: assert rst in the cycle a match occurs, with mtc0 Count=0x7 also asserted -> next cycle Count=0, Compare=0, equal=0.
